// File: rtl/i2c_master_pkg.sv
// Shared constants and types for the byte-level I2C master: register map,
// command bit positions, sequencer states and quarter-bit index.
package i2c_master_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  localparam int CMD_START = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_WRITE = 2;
  localparam int CMD_READ  = 3;
  localparam int CMD_NACK  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BIT   = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  typedef logic [1:0] quarter_t;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: down-counter that reloads to div, so one
// quarter lasts div+1 clocks; restart realigns the quarter grid.
module i2c_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= div;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_byte_master.sv
// Avalon-MM I2C master sequencing START, one byte (write or read) and STOP
// on open-drain SCL/SDA; software writes DATA and CMD, then polls STATUS.
module i2c_byte_master
  import i2c_master_pkg::*;
#(
  parameter int DIV_DEFAULT = 125,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output state_e      dbg_state
);

  // Avalon handshake: a register write happens on every clock where
  // chipselect=1 and write_n=0 (no wait states); readdata is the registered
  // value of the register addressed in the previous cycle.

  state_e           state_q, state_n;
  quarter_t         quarter_q, quarter_n;
  logic [3:0]       bit_q, bit_n;
  logic [7:0]       data_q, shift_q;
  logic [DIV_W-1:0] div_q;
  logic             op_byte_q, op_stop_q, op_read_q, op_nack_q;
  logic             done_q, rx_ack_q, pend_q;
  logic             scl_oe_q, sda_oe_q, scl_oe_n, sda_oe_n;
  logic             wr_en, busy, accept, go, stretch_q1, tick, restart;
  logic             byte_read, nack, msb, slot_sda;
  logic             unused_bits;

  assign wr_en       = chipselect & ~write_n;
  assign busy        = (state_q != ST_IDLE);
  assign accept      = wr_en && (address == ADDR_CMD) && !busy && (|writedata[3:0]);
  assign stretch_q1  = ((state_q == ST_BIT) || (state_q == ST_STOP)) && (quarter_q == 2'd1);
  // A tick seen while a slave holds SCL low is remembered; the phase then
  // advances as soon as SCL is released and the quarter grid restarts there.
  assign go          = busy && (stretch_q1 ? ((tick | pend_q) & scl_in) : tick);
  assign restart     = accept | (go & pend_q);
  assign scl_oe      = scl_oe_q;
  assign sda_oe      = sda_oe_q;
  assign dbg_state   = state_q;
  assign unused_bits = &{1'b0, writedata[31:DIV_W], writedata[7:5]};

  i2c_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .div     (div_q),
    .tick    (tick)
  );

  always_comb begin
    state_n   = state_q;
    quarter_n = quarter_q;
    bit_n     = bit_q;
    scl_oe_n  = scl_oe_q;
    sda_oe_n  = sda_oe_q;
    if (accept) begin
      quarter_n = 2'd0;
      bit_n     = 4'd0;
      if (writedata[CMD_START])                            state_n = ST_START;
      else if (writedata[CMD_WRITE] || writedata[CMD_READ]) state_n = ST_BIT;
      else                                                 state_n = ST_STOP;
    end else if (go) begin
      quarter_n = quarter_q + 2'd1;
      if (quarter_q == 2'd3) begin
        case (state_q)
          ST_START: state_n = op_byte_q ? ST_BIT : (op_stop_q ? ST_STOP : ST_IDLE);
          ST_BIT: begin
            if (bit_q != 4'd8) bit_n = bit_q + 4'd1;
            else               state_n = op_stop_q ? ST_STOP : ST_IDLE;
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end
    // Value driven in the slot being entered; shift_q is not loaded yet on accept.
    byte_read = accept ? (writedata[CMD_READ] & ~writedata[CMD_WRITE]) : op_read_q;
    nack      = accept ? writedata[CMD_NACK] : op_nack_q;
    msb       = accept ? data_q[7] : shift_q[7];
    slot_sda  = (bit_n == 4'd8) ? (byte_read & ~nack) : (~byte_read & ~msb);
    if (accept || go) begin
      case (state_n)
        ST_START: begin
          case (quarter_n)
            2'd0:    begin scl_oe_n = 1'b0; sda_oe_n = 1'b0; end
            2'd2:    sda_oe_n = 1'b1;
            2'd3:    scl_oe_n = 1'b1;
            default: ;
          endcase
        end
        ST_BIT: begin
          case (quarter_n)
            2'd0:    begin scl_oe_n = 1'b1; sda_oe_n = slot_sda; end
            2'd1:    scl_oe_n = 1'b0;
            2'd3:    scl_oe_n = 1'b1;
            default: ;
          endcase
        end
        ST_STOP: begin
          case (quarter_n)
            2'd0:    begin scl_oe_n = 1'b1; sda_oe_n = 1'b1; end
            2'd1:    scl_oe_n = 1'b0;
            2'd3:    sda_oe_n = 1'b0;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      quarter_q <= 2'd0;
      bit_q     <= 4'd0;
      data_q    <= 8'd0;
      shift_q   <= 8'd0;
      div_q     <= DIV_W'(DIV_DEFAULT);
      op_byte_q <= 1'b0;
      op_stop_q <= 1'b0;
      op_read_q <= 1'b0;
      op_nack_q <= 1'b0;
      done_q    <= 1'b0;
      rx_ack_q  <= 1'b1;
      pend_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      readdata  <= 32'd0;
    end else begin
      state_q   <= state_n;
      quarter_q <= quarter_n;
      bit_q     <= bit_n;
      scl_oe_q  <= scl_oe_n;
      sda_oe_q  <= sda_oe_n;
      if (accept) begin
        op_byte_q <= writedata[CMD_WRITE] | writedata[CMD_READ];
        op_stop_q <= writedata[CMD_STOP];
        op_read_q <= writedata[CMD_READ] & ~writedata[CMD_WRITE];
        op_nack_q <= writedata[CMD_NACK];
        shift_q   <= data_q;
        done_q    <= 1'b0;
      end
      if (wr_en && (address == ADDR_DATA) && !busy) data_q <= writedata[7:0];
      if (wr_en && (address == ADDR_DIV) && !busy)  div_q  <= writedata[DIV_W-1:0];
      if (go)                                       pend_q <= 1'b0;
      else if (busy && stretch_q1 && tick && !scl_in) pend_q <= 1'b1;
      if (go && (state_q == ST_BIT) && (quarter_q == 2'd2)) begin
        if (bit_q != 4'd8)   shift_q  <= {shift_q[6:0], sda_in};
        else if (!op_read_q) rx_ack_q <= sda_in;
      end
      if (go && (state_n == ST_IDLE)) begin
        done_q <= 1'b1;
        if (op_read_q) data_q <= shift_q;
      end
      case (address)
        ADDR_DATA:   readdata <= {24'd0, data_q};
        ADDR_CMD:    readdata <= 32'd0;
        ADDR_STATUS: readdata <= {29'd0, done_q, rx_ack_q, busy};
        default:     readdata <= 32'(div_q);
      endcase
    end
  end

endmodule
